// File: rtl/serial_word_feeder.sv
// ============================================================================
// serial_word_feeder
// Parallel-in/serial-out word feeder with a one-word holding register and
// per-word bit order, framing strobes for a downstream serial detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_word_feeder #(
  parameter int W  = 4,
  parameter int CW = $clog2(W)  // derived from W; leave at default
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_in,
  input  logic         msb_first,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         word_done,
  output logic         busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t        r_state, w_state_n;
  logic [W-1:0]  r_sh, w_sh_n;
  logic          r_order, w_order_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [W-1:0]  r_hold, w_hold_n;
  logic          r_hold_order, w_hold_order_n;
  logic          r_hold_full, w_hold_full_n;

  logic w_xfer;
  logic w_last;

  assign load_ready = !rst && !r_hold_full;
  assign w_xfer     = load_valid && load_ready;
  assign w_last     = (r_cnt == CW'(W - 1));

  // Outputs decode registered state only, so no input reaches ser_out/ser_valid.
  assign ser_valid = (r_state == S_SHIFT);
  assign ser_out   = (r_state == S_SHIFT) ? (r_order ? r_sh[W-1] : r_sh[0]) : 1'b0;
  assign word_done = (r_state == S_SHIFT) && w_last;
  assign busy      = (r_state == S_SHIFT) || r_hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sh         <= '0;
      r_order      <= 1'b0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_order <= 1'b0;
      r_hold_full  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_sh         <= w_sh_n;
      r_order      <= w_order_n;
      r_cnt        <= w_cnt_n;
      r_hold       <= w_hold_n;
      r_hold_order <= w_hold_order_n;
      r_hold_full  <= w_hold_full_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_sh_n         = r_sh;
    w_order_n      = r_order;
    w_cnt_n        = r_cnt;
    w_hold_n       = r_hold;
    w_hold_order_n = r_hold_order;
    w_hold_full_n  = r_hold_full;

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_sh_n    = data_in;
          w_order_n = msb_first;
          w_cnt_n   = '0;
          w_state_n = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (w_last) begin
          // Held word has priority; load_ready is low whenever it is present.
          if (r_hold_full) begin
            w_sh_n        = r_hold;
            w_order_n     = r_hold_order;
            w_hold_full_n = 1'b0;
            w_cnt_n       = '0;
          end else if (w_xfer) begin
            w_sh_n    = data_in;
            w_order_n = msb_first;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n   = '0;
            w_state_n = S_IDLE;
          end
        end else begin
          w_sh_n  = r_order ? (r_sh << 1) : (r_sh >> 1);
          w_cnt_n = r_cnt + CW'(1);
          if (w_xfer) begin
            w_hold_n       = data_in;
            w_hold_order_n = msb_first;
            w_hold_full_n  = 1'b1;
          end
        end
      end

      default: w_state_n = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_word_feeder.sv
// ============================================================================
// tb_serial_word_feeder
// Directed self-checking bench for serial_word_feeder (W = 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_word_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       msb_first;
  logic       load_valid;
  logic       load_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       word_done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  serial_word_feeder #(.W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .msb_first  (msb_first),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .word_done  (word_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic b, input logic wd);
    chk({tag, ".ser_valid"}, ser_valid, 1'b1);
    chk({tag, ".ser_out"},   ser_out,   b);
    chk({tag, ".word_done"}, word_done, wd);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ser_valid"}, ser_valid, 1'b0);
    chk({tag, ".ser_out"},   ser_out,   1'b0);
    chk({tag, ".word_done"}, word_done, 1'b0);
    chk({tag, ".busy"},      busy,      1'b0);
  endtask

  logic [11:0] exp_s;
  logic [11:0] exp_lr;
  logic [3:0]  exp4;

  initial begin
    rst        = 1'b1;
    data_in    = 4'b0000;
    msb_first  = 1'b0;
    load_valid = 1'b0;

    // Reset state
    step();
    step();
    chk_idle("reset");
    chk("reset.load_ready", load_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_reset.load_ready", load_ready, 1'b1);

    // Single word MSB-first: 1011 -> 1,0,1,1
    data_in = 4'b1011; msb_first = 1'b1; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    exp4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk_bit("msb1", exp4[3-i], i == 3);
    end
    step();
    chk_idle("msb1.end");

    // Single word LSB-first: 1011 -> 1,1,0,1
    data_in = 4'b1011; msb_first = 1'b0; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    exp4 = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk_bit("lsb1", exp4[3-i], i == 3);
    end
    step();
    chk_idle("lsb1.end");

    // Three words back-to-back; third offered while holding register is full
    exp_s  = 12'b1011_0110_1100;
    exp_lr = 12'b1000_1000_1111;
    data_in = 4'b1011; msb_first = 1'b1; load_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_bit("b2b", exp_s[11-i], (i % 4) == 3);
      chk("b2b.load_ready", load_ready, exp_lr[11-i]);
      if (i == 0) data_in = 4'b0110;
      if (i == 1) data_in = 4'b1100;
      if (i == 5) load_valid = 1'b0;
    end
    step();
    chk_idle("b2b.end");

    // Reset mid-word with a word held
    data_in = 4'b1011; msb_first = 1'b1; load_valid = 1'b1;
    step();
    data_in = 4'b0110;
    step();
    load_valid = 1'b0;
    chk("rst_mid.busy_before", busy, 1'b1);
    chk("rst_mid.load_ready_before", load_ready, 1'b0);
    step();
    chk_bit("rst_mid.bit2", 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_idle("rst_mid.async");
    chk("rst_mid.load_ready", load_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk_idle("rst_mid.released");
    step();
    chk_idle("rst_mid.no_residue");
    step();
    chk_idle("rst_mid.no_residue2");

    data_in = 4'b1001; msb_first = 1'b1; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    exp4 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk_bit("after_rst", exp4[3-i], i == 3);
    end
    step();
    chk_idle("after_rst.end");

    // Order switch between words: A=0011 LSB-first, B=0011 MSB-first
    exp_s = 12'b0000_1100_0011;
    data_in = 4'b0011; msb_first = 1'b0; load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_bit("order", exp_s[7-i], (i % 4) == 3);
      if (i == 0) msb_first = 1'b1;
      if (i == 1) load_valid = 1'b0;
    end
    step();
    chk_idle("order.end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Parallel-in/serial-out feeder that sits directly upstream of the 1011 sequence detector and drives its one-bit serial input.
- Accepts W-bit words over a valid/ready handshake and emits them one bit per clock, MSB-first or LSB-first.
- A one-word holding register keeps back-to-back words gapless.
- Also provides the bit-valid qualifier and word-boundary strobe that downstream stages use for framing.

Parameters:
- W, 4, word width in bits; legal range W >= 2.
- CW, $clog2(W), bit-counter width; derived, must not be overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  W  parallel word to serialize.
- msb_first  input  1  bit order for the word offered this cycle: 1 = MSB-first, 0 = LSB-first.
- load_valid  input  1  data_in/msb_first valid.
- load_ready  output  1  feeder can accept a word this cycle.
- ser_out  output  1  serial bit; connects to the detector's data input.
- ser_valid  output  1  ser_out carries a real data bit this cycle.
- word_done  output  1  high during the cycle the last bit of a word is on ser_out.
- busy  output  1  shifter active or holding register occupied.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high. While rst = 1:
  - shifter cleared, bit counter 0, holding register empty, state IDLE;
  - ser_out = 0, ser_valid = 0, word_done = 0, busy = 0, load_ready = 0.
  - First acceptance is possible on the first clk edge after rst deasserts.
- Handshake:
  - Transfer occurs on a rising edge where load_valid = 1 and load_ready = 1.
  - load_ready = !rst && !hold_full, purely combinational from registers; it never depends on load_valid.
  - data_in and msb_first are sampled together at transfer. The order bit is stored with the word and applies to that word only.
  - load_valid with load_ready = 0 is ignored. The source must hold data stable until transfer.
- State machine:
  - IDLE: ser_valid = 0, ser_out = 0.
    - On transfer, the word loads straight into the shifter (bypass) and state becomes SHIFT with count = 0.
    - The first bit appears on ser_out in the cycle immediately after the transfer edge (latency 1 cycle).
  - SHIFT: ser_out = sh[W-1] if the stored order is MSB-first, else sh[0]; ser_valid = 1.
    - Each edge shifts toward the output end and increments count.
    - word_done = 1 when count == W-1.
    - At the edge ending count == W-1, the first applicable source below is taken:
      - hold_full: hold moves to the shifter, hold empties, state stays SHIFT, count = 0.
      - a transfer occurs on the same edge (hold empty): the incoming word bypasses into the shifter, state stays SHIFT, count = 0.
      - neither: state returns to IDLE.
    - A transfer in SHIFT at any other count writes the holding register (hold_full = 1).
- Holding register: a transfer is never accepted into a full holding register, so no overwrite is possible.
  - Simultaneous hold-to-shifter move and a new transfer cannot occur on the same edge, because load_ready = 0 whenever hold_full = 1.
- Throughput: continuous load_valid gives W valid bits per W cycles with no ser_valid gap between words.
- busy = (state == SHIFT) || hold_full.
- ser_out and ser_valid come directly from registers (no combinational path from inputs) so the detector sees glitch-free data.
- Reset mid-word: the current word and held word are discarded with no partial completion. ser_valid and word_done drop asynchronously with rst.
- Order switching: msb_first may change between words; it takes effect only at that word's transfer, never mid-word.

Test Plan:
- After reset, offer 4'b1011 with msb_first = 1 for one cycle -> ser_out = 1,0,1,1 on the next 4 cycles with ser_valid = 1. word_done is high on the 4th bit only; then ser_valid = 0, busy = 0.
- Offer 4'b1011 with msb_first = 0 -> ser_out = 1,1,0,1; word_done on the 4th bit.
- Hold load_valid = 1 with 4'b1011 then 4'b0110 (MSB-first), both accepted -> 8 consecutive ser_valid cycles with stream 1,0,1,1,0,1,1,0 and no gap. load_ready is 0 while the holding register is full; word_done pulses on cycles 4 and 8.
- Offer a third word while the shifter is active and the holding register is full -> load_ready = 0 and the word is not taken. It transfers on the first edge with load_ready = 1 and its bits follow the second word with no gap.
- Assert rst for 1 cycle at bit 2 of 4'b1011 with a word held -> ser_valid, word_done and busy drop immediately; no remaining bits are emitted. A new 4'b1001 after reset serializes as 1,0,0,1.
- Set msb_first = 0 for word A = 4'b0011 and 1 for word B = 4'b0011, back-to-back -> stream 1,1,0,0,0,0,1,1.
